// File: rtl/oai32_exhaustive_bist.sv
// Exhaustive self-test for an OAI32 cell: applies all 32 input vectors, samples ZN, counts mismatches.
// Optional first-failure capture register enabled by defining OAI32_BIST_FAIL_CAPTURE_EN.
module oai32_exhaustive_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B1,
  output logic             B2,
  input  logic             ZN,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       first_fail,
  output logic             fail_seen
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [4:0] vec;
  logic [4:0] drv;
  logic [3:0] cnt;
  logic       sample;
  logic       mismatch;
  logic       accept;

  function automatic logic golden(input logic [4:0] v);
    return ~((v[0] | v[1] | v[2]) & (v[3] | v[4]));
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  assign sample   = (state == RUN) && (cnt == SETTLE_LAST);
  assign mismatch = (ZN != golden(vec));
  assign accept   = start && ((state == IDLE) || (state == FIN));

  assign {B2, B1, A3, A2, A1} = drv;
  assign pass = done && (err_count == '0);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      vec       <= 5'd0;
      drv       <= 5'd0;
      cnt       <= 4'd0;
      err_count <= '0;
      fail_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state     <= RUN;
            vec       <= 5'd0;
            drv       <= 5'd0;
            cnt       <= 4'd0;
            err_count <= '0;
            fail_seen <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          if (cnt == SETTLE_LAST) begin
            if (mismatch) begin
              err_count <= sat_inc(err_count);
              fail_seen <= 1'b1;
            end
            // Next vector is launched on the same edge that samples the current one.
            if (vec == 5'd31) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              drv   <= 5'd0;
            end else begin
              vec <= vec + 5'd1;
              drv <= vec + 5'd1;
              cnt <= 4'd0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OAI32_BIST_FAIL_CAPTURE_EN
  logic [4:0] first_fail_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      first_fail_q <= 5'd0;
    end else if (accept) begin
      first_fail_q <= 5'd0;
    end else if (sample && mismatch && !fail_seen) begin
      first_fail_q <= vec;
    end
  end

  assign first_fail = first_fail_q;
`else
  assign first_fail = 5'd0;
`endif

endmodule

// File: tb/tb_oai32_exhaustive_bist.sv
// Bench for oai32_exhaustive_bist: behavioural cell with injectable faults and a per-run result model.
module tb_oai32_exhaustive_bist;

  localparam int S   = 2;
  localparam int PER = S + 1;
  localparam int RUN_CYC = 32 * PER;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       a1, a2, a3, b1, b2, zn;
  logic       busy, done, pass, fail_seen;
  logic [5:0] err_count;
  logic [4:0] first_fail;

  logic       c1, c2, c3, d1, d2;
  logic       busy2, done2, pass2, fail_seen2;
  logic [3:0] err_count2;
  logic [4:0] first_fail2;

  int          mode = 0;
  logic [31:0] mask = 32'd0;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  oai32_exhaustive_bist #(.SETTLE_CYCLES(S), .ERR_W(6)) dut (
    .CLK(CLK), .RN(RN), .start(start),
    .A1(a1), .A2(a2), .A3(a3), .B1(b1), .B2(b2), .ZN(zn),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .fail_seen(fail_seen)
  );

  oai32_exhaustive_bist #(.SETTLE_CYCLES(S), .ERR_W(4)) dut_w4 (
    .CLK(CLK), .RN(RN), .start(start2),
    .A1(c1), .A2(c2), .A3(c3), .B1(d1), .B2(d2), .ZN(1'b1),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_fail(first_fail2), .fail_seen(fail_seen2)
  );

  // Ideal OAI32: output is 1 unless some A input and some B input are both high.
  function automatic logic ideal_out(input int v);
    return ((v % 8) == 0 || (v / 8) == 0) ? 1'b1 : 1'b0;
  endfunction

  // Cell under test: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ideal with per-vector flips.
  function automatic logic cell_out(input int md, input logic [31:0] m, input int v);
    case (md)
      1: return 1'b0;
      2: return 1'b1;
      3: return ideal_out(v) ^ m[v];
      default: return ideal_out(v);
    endcase
  endfunction

  always_comb zn = cell_out(mode, mask, int'({b2, b1, a3, a2, a1}));

  task automatic model_run(input int err_max, output int exp_err, output int exp_first,
                           output logic exp_seen);
    int n = 0;
    exp_first = 0;
    exp_seen  = 1'b0;
    for (int v = 0; v < 32; v++) begin
      if (cell_out(mode, mask, v) != ideal_out(v)) begin
        if (!exp_seen) exp_first = v;
        exp_seen = 1'b1;
        n++;
      end
    end
    exp_err = (n > err_max) ? err_max : n;
`ifndef OAI32_BIST_FAIL_CAPTURE_EN
    exp_first = 0;
`endif
  endtask

  task automatic run_full(input string name, input int restart_at, input bit late_start);
    int   exp_err, exp_first;
    logic exp_seen;
    int   done_cyc = -1;
    int   vec_bad = 0;
    int   busy_bad = 0;
    model_run(63, exp_err, exp_first, exp_seen);
    @(negedge CLK) start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int c = 0; c <= RUN_CYC; c++) begin
      if (c > 0) begin
        @(posedge CLK);
        #1;
      end
      start = (c == restart_at) || (late_start && c == RUN_CYC - 1);
      if (int'({b2, b1, a3, a2, a1}) != ((c < RUN_CYC) ? c / PER : 0)) vec_bad++;
      if (busy !== (c < RUN_CYC)) busy_bad++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
    end
    start = 1'b0;
    checks++;
    if (done_cyc !== RUN_CYC) begin
      failures++;
      $display("FAIL %s done_cycle actual=%0d required=%0d", name, done_cyc, RUN_CYC);
    end
    checks++;
    if (vec_bad !== 0) begin
      failures++;
      $display("FAIL %s drive_sequence bad_cycles=%0d required=0", name, vec_bad);
    end
    checks++;
    if (busy_bad !== 0) begin
      failures++;
      $display("FAIL %s busy_profile bad_cycles=%0d required=0", name, busy_bad);
    end
    checks++;
    if (int'(err_count) !== exp_err) begin
      failures++;
      $display("FAIL %s err_count actual=%0d required=%0d", name, err_count, exp_err);
    end
    checks++;
    if (fail_seen !== exp_seen) begin
      failures++;
      $display("FAIL %s fail_seen actual=%0b required=%0b", name, fail_seen, exp_seen);
    end
    checks++;
    if (int'(first_fail) !== exp_first) begin
      failures++;
      $display("FAIL %s first_fail actual=%0d required=%0d", name, first_fail, exp_first);
    end
    checks++;
    if (pass !== (exp_err == 0)) begin
      failures++;
      $display("FAIL %s pass actual=%0b required=%0b", name, pass, exp_err == 0);
    end
    if (late_start) begin
      @(posedge CLK);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s late_start done=%0b busy=%0b required done=1 busy=0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, pass, fail_seen, err_count, first_fail, a1, a2, a3, b1, b2} !== '0) begin
      failures++;
      $display("FAIL reset_values actual=%b required=0",
               {busy, done, pass, fail_seen, err_count, first_fail, a1, a2, a3, b1, b2});
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK) RN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset busy/done/pass actual=%b required=000", {busy, done, pass});
    end
  endtask

  task automatic test_ideal();
    mode = 0;
    run_full("ideal", -1, 1'b0);
  endtask

  task automatic test_stuck0();
    mode = 1;
    run_full("stuck0", -1, 1'b0);
  endtask

  task automatic test_stuck1();
    mode = 2;
    run_full("stuck1", -1, 1'b0);
  endtask

  task automatic test_random_faults();
    mode = 3;
    for (int i = 0; i < 4; i++) begin
      mask = $urandom;
      if (i == 0) mask = 32'h8000_0000;
      run_full($sformatf("random%0d", i), -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2;
    run_full("restart_mid_run", 40, 1'b0);
    mode = 0;
    run_full("late_start", -1, 1'b1);
    mode = 1;
    run_full("rerun_after_done", -1, 1'b0);
  endtask

  task automatic test_saturation();
    int   exp_err, exp_first;
    logic exp_seen;
    int   decreases = 0;
    logic [3:0] prev = 4'd0;
    int   saved_mode = mode;
    mode = 2;
    model_run(15, exp_err, exp_first, exp_seen);
    mode = saved_mode;
    @(negedge CLK) start2 = 1'b1;
    @(posedge CLK);
    #1 start2 = 1'b0;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(posedge CLK);
      #1;
      if (err_count2 < prev) decreases++;
      prev = err_count2;
    end
    checks++;
    if (int'(err_count2) !== exp_err || decreases !== 0) begin
      failures++;
      $display("FAIL w4_saturation err_count=%0d decreases=%0d required=%0d/0",
               err_count2, decreases, exp_err);
    end
    checks++;
    if ({done2, busy2, pass2, fail_seen2} !== 4'b1001) begin
      failures++;
      $display("FAIL w4_flags done/busy/pass/fail_seen actual=%b required=1001",
               {done2, busy2, pass2, fail_seen2});
    end
    checks++;
    if (int'(first_fail2) !== exp_first || {c1, c2, c3, d1, d2} !== 5'd0) begin
      failures++;
      $display("FAIL w4_first_fail/drive actual=%0d/%b required=%0d/00000",
               first_fail2, {c1, c2, c3, d1, d2}, exp_first);
    end
  endtask

  task automatic test_async_reset();
    mode = 2;
    @(negedge CLK) start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (50) @(posedge CLK);
    #2 RN = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, fail_seen, err_count, first_fail, a1, a2, a3, b1, b2} !== '0) begin
      failures++;
      $display("FAIL async_reset actual=%b required=0",
               {busy, done, pass, fail_seen, err_count, first_fail, a1, a2, a3, b1, b2});
    end
    @(negedge CLK) RN = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, pass, err_count} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle busy/done/pass/err actual=%b required=0",
               {busy, done, pass, err_count});
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck0();
    test_stuck1();
    test_random_faults();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
